// File: rtl/game_flow_controller.sv
// Top-level game sequencer: title -> start -> play -> hit/clear -> game-over.
// Holds the stage timer and enemy controllers in reset outside active play, tracks lives and a
// saturating score, and counts kills from falling edges of the (enabled) enemy alive vector.
//
// Ports
//   clk25        25 MHz pixel clock, all state on posedge
//   rst_n        asynchronous active-low reset
//   frame_tick   1-cycle pulse per frame
//   btn_fire     raw asynchronous fire button, rising edge used as the start key
//   player_hit   1-cycle collision pulse
//   seconds      game timer seconds
//   enemy_alive  per-enemy alive flags
//   enable_enemy per-enemy enable flags from the stage controller
//   stage_rst    holds the game timer at 0
//   enemy_rst    resets the enemy controllers
//   play_en      movement/fire allowed
//   player_blink hide the player sprite this frame (HIT only)
//   game_state   IDLE=0 START=1 PLAY=2 HIT=3 CLEAR=4 OVER=5
//   lives        remaining lives
//   score        saturating score
module game_flow_controller #(
  parameter int unsigned ENEMY_COUNT    = 23,
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned START_FRAMES   = 60,
  parameter int unsigned HIT_FRAMES     = 90,
  parameter int unsigned CLEAR_SEC      = 60,
  parameter int unsigned SCORE_PER_KILL = 10
) (
  input  logic                   clk25,
  input  logic                   rst_n,
  input  logic                   frame_tick,
  input  logic                   btn_fire,
  input  logic                   player_hit,
  input  logic [7:0]             seconds,
  input  logic [ENEMY_COUNT-1:0] enemy_alive,
  input  logic [ENEMY_COUNT-1:0] enable_enemy,
  output logic                   stage_rst,
  output logic                   enemy_rst,
  output logic                   play_en,
  output logic                   player_blink,
  output logic [2:0]             game_state,
  output logic [1:0]             lives,
  output logic [15:0]            score
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StPlay  = 3'd2,
    StHit   = 3'd3,
    StClear = 3'd4,
    StOver  = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             lives_q, lives_d;
  logic [15:0]            score_q, score_d;
  logic [7:0]             frame_cnt_q, frame_cnt_d;
  logic [ENEMY_COUNT-1:0] prev_alive_q;
  logic                   sync1_q, sync2_q, btn_prev_q;
  logic                   stage_rst_q, stage_rst_d;
  logic                   enemy_rst_q, enemy_rst_d;
  logic                   play_en_q, play_en_d;
  logic                   blink_q, blink_d;

  logic                   start_key;
  logic [ENEMY_COUNT-1:0] kill_vec;
  logic [31:0]            kill_cnt;
  logic [31:0]            score_sum;
  logic                   clear_cond;

  assign start_key  = sync2_q & ~btn_prev_q;
  // Enable masks both sides so toggling an enable bit alone can never look like a kill.
  assign kill_vec   = prev_alive_q & ~enemy_alive & enable_enemy;
  assign clear_cond = (seconds >= 8'(CLEAR_SEC)) && ((enemy_alive & enable_enemy) == '0);

  always_comb begin
    kill_cnt = '0;
    for (int i = 0; i < ENEMY_COUNT; i++) begin
      kill_cnt = kill_cnt + 32'(kill_vec[i]);
    end
    score_sum = 32'(score_q) + kill_cnt * SCORE_PER_KILL;
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;

    if (state_q == StPlay || state_q == StHit) begin
      score_d = (score_sum > 32'h0000_FFFF) ? 16'hFFFF : score_sum[15:0];
    end

    unique case (state_q)
      StIdle: begin
        if (start_key) begin
          state_d = StStart;
          lives_d = 2'(LIVES_INIT);
          score_d = '0;
        end
      end
      StStart: begin
        if (frame_tick && frame_cnt_q == 8'(START_FRAMES - 1)) state_d = StPlay;
      end
      StPlay: begin
        if (player_hit) begin
          if (lives_q <= 2'd1) begin
            state_d = StOver;
            lives_d = '0;
          end else begin
            state_d = StHit;
            lives_d = lives_q - 2'd1;
          end
        end else if (clear_cond) begin
          state_d = StClear;
        end
      end
      StHit: begin
        if (frame_tick && frame_cnt_q == 8'(HIT_FRAMES - 1)) state_d = StPlay;
      end
      StClear: begin
        if (start_key) state_d = StStart;
      end
      StOver: begin
        if (start_key) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      frame_cnt_d = '0;
    end else if (frame_tick) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    // Outputs derive from next state so they change on the same edge as game_state.
    stage_rst_d = 1'b1;
    enemy_rst_d = 1'b1;
    play_en_d   = 1'b0;
    blink_d     = 1'b0;
    if (state_d == StPlay || state_d == StHit) begin
      stage_rst_d = 1'b0;
      enemy_rst_d = 1'b0;
      play_en_d   = 1'b1;
    end
    if (state_d == StHit) blink_d = frame_cnt_d[2];
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      lives_q      <= '0;
      score_q      <= '0;
      frame_cnt_q  <= '0;
      prev_alive_q <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      btn_prev_q   <= 1'b0;
      stage_rst_q  <= 1'b1;
      enemy_rst_q  <= 1'b1;
      play_en_q    <= 1'b0;
      blink_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      frame_cnt_q  <= frame_cnt_d;
      prev_alive_q <= enemy_alive & enable_enemy;
      sync1_q      <= btn_fire;
      sync2_q      <= sync1_q;
      btn_prev_q   <= sync2_q;
      stage_rst_q  <= stage_rst_d;
      enemy_rst_q  <= enemy_rst_d;
      play_en_q    <= play_en_d;
      blink_q      <= blink_d;
    end
  end

  assign stage_rst    = stage_rst_q;
  assign enemy_rst    = enemy_rst_q;
  assign play_en      = play_en_q;
  assign player_blink = blink_q;
  assign game_state   = state_q;
  assign lives        = lives_q;
  assign score        = score_q;

endmodule
